// File: rtl/dwt_pkg.sv
// Shared definitions for the Haar DWT/IDWT blocks: FSM states, level sizing and
// the lifting shift used by both the forward and inverse transforms.
package dwt_pkg;

  typedef enum logic [1:0] {
    StLoad,
    StRecon,
    StDrain
  } state_e;

  localparam int unsigned LiftShift = 1;

  // Number of approximation entries at decomposition level l.
  function automatic int unsigned level_size(input int unsigned n, input int unsigned l);
    return n >> l;
  endfunction

endpackage

// File: rtl/idwt_haar_pair.sv
// Inverse Haar lifting butterfly: rebuilds one sample pair from (a, d), modulo 2^W.
module idwt_haar_pair
  import dwt_pkg::*;
#(
  parameter int unsigned W = 8
) (
  input  logic signed [W-1:0] a,
  input  logic signed [W-1:0] d,
  output logic signed [W-1:0] x0,
  output logic signed [W-1:0] x1
);

  always_comb begin
    x1 = a - (d >>> LiftShift);
    x0 = d + x1;
  end

endmodule

// File: rtl/idwt_haar.sv
// Inverse multi-level Haar transform: buffers a Mallat-ordered coefficient frame, rebuilds
// it one butterfly per cycle in ping-pong banks, then streams samples out.
// Define IDWT_FRAME_CHECK_EN to flag in_last placement errors on frame_err.
module idwt_haar
  import dwt_pkg::*;
#(
  parameter int unsigned N = 8,
  parameter int unsigned L = 3,
  parameter int unsigned W = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic signed [W-1:0] in_data,
  input  logic                in_last,
  output logic                out_valid,
  input  logic                out_ready,
  output logic signed [W-1:0] out_data,
  output logic                out_last,
  output logic                busy,
  output logic                frame_err
);

  localparam int unsigned AW = $clog2(N);
  localparam int unsigned LW = $clog2(L + 1);
  localparam logic [AW-1:0] LastIdx = AW'(N - 1);

  state_e state_q, state_d;
  logic [AW-1:0] cnt_q, idx_q, k_q;
  logic [LW-1:0] lvl_q;
  logic          sel_q;  // bank holding the current level's source data

  logic signed [W-1:0] bank [2][N];

  int unsigned         half;
  logic [AW-1:0]       d_addr, lo_addr, hi_addr;
  logic                last_pair, load_we, recon_we;
  logic signed [W-1:0] a_val, d_val, x0, x1;

  always_comb begin
    half      = level_size(N, int'(lvl_q));
    d_addr    = AW'(half) + k_q;
    lo_addr   = AW'({k_q, 1'b0});
    hi_addr   = lo_addr + AW'(1);
    last_pair = (k_q == AW'(half - 1));
    load_we   = (state_q == StLoad) && in_valid;
    recon_we  = (state_q == StRecon);
    a_val     = bank[sel_q][k_q];
    d_val     = bank[sel_q][d_addr];
  end

  idwt_haar_pair #(
    .W(W)
  ) u_pair (
    .a (a_val),
    .d (d_val),
    .x0(x0),
    .x1(x1)
  );

  always_ff @(posedge clk) begin
    if (reset) state_q <= StLoad;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StLoad:  if (in_valid && cnt_q == LastIdx) state_d = StRecon;
      StRecon: if (last_pair && lvl_q == LW'(1)) state_d = StDrain;
      StDrain: if (out_ready && idx_q == LastIdx) state_d = StLoad;
      default: state_d = StLoad;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == StLoad);
    out_valid = (state_q == StDrain);
    busy      = (state_q == StRecon) || (state_q == StDrain);
    out_last  = (state_q == StDrain) && (idx_q == LastIdx);
    out_data  = (state_q == StDrain) ? bank[sel_q][idx_q] : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      idx_q <= '0;
      k_q   <= '0;
      lvl_q <= LW'(L);
      sel_q <= 1'b0;
    end else begin
      if (load_we) begin
        cnt_q <= (cnt_q == LastIdx) ? '0 : cnt_q + AW'(1);
        k_q   <= '0;
        lvl_q <= LW'(L);
        sel_q <= 1'b0;
      end
      if (recon_we) begin
        if (last_pair) begin
          k_q   <= '0;
          lvl_q <= lvl_q - LW'(1);
          sel_q <= ~sel_q;
        end else begin
          k_q <= k_q + AW'(1);
        end
      end
      if (state_q == StDrain && out_ready) begin
        idx_q <= (idx_q == LastIdx) ? '0 : idx_q + AW'(1);
      end
    end
  end

  // Destination bank gets the butterfly pair plus an untouched copy of the finer details.
  always_ff @(posedge clk) begin
    for (int unsigned b = 0; b < 2; b++) begin
      for (int unsigned i = 0; i < N; i++) begin
        if (b == 0 && load_we && cnt_q == AW'(i)) begin
          bank[1'(b)][AW'(i)] <= in_data;
        end else if (recon_we && sel_q != 1'(b)) begin
          if (lo_addr == AW'(i))      bank[1'(b)][AW'(i)] <= x0;
          else if (hi_addr == AW'(i)) bank[1'(b)][AW'(i)] <= x1;
          else if (i >= 2 * half)     bank[1'(b)][AW'(i)] <= bank[sel_q][AW'(i)];
        end
      end
    end
  end

`ifdef IDWT_FRAME_CHECK_EN
  logic err_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      err_q <= 1'b0;
    end else if (load_we && (in_last != (cnt_q == LastIdx))) begin
      err_q <= 1'b1;
    end
  end
  assign frame_err = err_q;
`else
  logic unused_in_last;
  assign unused_in_last = in_last;
  assign frame_err      = 1'b0;
`endif

endmodule
